// File: rtl/microwave_timer.sv
// microwave_timer: BCD cook-time entry and per-second countdown with finish flag
module microwave_timer #(
  parameter int TICKS_PER_SEC = 1000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  input  logic        clear,
  input  logic        heat,
  output logic [15:0] disp,
  output logic        finish
);
  localparam int PW = $clog2(TICKS_PER_SEC);
  logic [PW-1:0] pre;
  logic [15:0]   tm, tm_dec;
  logic          last_tick;
  assign disp = tm;
  assign last_tick = pre == PW'(TICKS_PER_SEC - 1);
  // Entered seconds are not normalised, so only the zero digits borrow.
  always_comb begin
    tm_dec = tm;
    if (tm[3:0] != 4'd0) tm_dec[3:0] = tm[3:0] - 4'd1;
    else if (tm[7:4] != 4'd0) begin
      tm_dec[7:4] = tm[7:4] - 4'd1;
      tm_dec[3:0] = 4'd9;
    end else if (tm[15:8] != 8'd0) begin
      tm_dec[7:0] = 8'h59;
      if (tm[11:8] != 4'd0) tm_dec[11:8] = tm[11:8] - 4'd1;
      else begin
        tm_dec[15:12] = tm[15:12] - 4'd1;
        tm_dec[11:8]  = 4'd9;
      end
    end
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tm     <= '0;
      pre    <= '0;
      finish <= 1'b0;
    end else begin
      finish <= heat && tm == 16'h0000;
      if (clear) begin
        tm  <= '0;
        pre <= '0;
      end else if (!heat && digit_valid && digit <= 4'd9) tm <= {tm[11:0], digit};
      else if (heat) begin
        pre <= last_tick ? '0 : pre + 1'b1;
        if (last_tick && tm != 16'h0000) tm <= tm_dec;
      end
    end
  end
endmodule

// File: tb/tb_microwave_timer.sv
// tb_microwave_timer: directed and random steps checked against a minutes/seconds model
module tb_microwave_timer;
  localparam int T = 4;
  logic clk = 1'b0, nrst = 1'b0, digit_valid = 1'b0, clear = 1'b0, heat = 1'b0;
  logic [3:0] digit = 4'd0;
  logic [15:0] disp;
  logic finish;
  int checks = 0, errors = 0;
  int m = 0, s = 0, p = 0;
  bit f = 1'b0;

  microwave_timer #(.TICKS_PER_SEC(T)) dut (
    .clk(clk), .nrst(nrst), .digit_valid(digit_valid), .digit(digit),
    .clear(clear), .heat(heat), .disp(disp), .finish(finish)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] bcd();
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit dv, input logic [3:0] d, input bit clr, input bit ht);
    digit_valid = dv; digit = d; clear = clr; heat = ht;
    @(posedge clk);
    f = ht && m == 0 && s == 0;
    if (clr) begin
      m = 0; s = 0; p = 0;
    end else if (!ht && dv && d <= 4'd9) begin
      m = (m % 10) * 10 + s / 10;
      s = (s % 10) * 10 + int'(d);
    end else if (ht) begin
      if (p == T - 1) begin
        p = 0;
        if (s > 0) s--;
        else if (m > 0) begin
          m--; s = 59;
        end
      end else p++;
    end
    #1;
    check("model_disp", disp, bcd());
    check("model_finish", {15'b0, finish}, {15'b0, f});
    digit_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic load(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b1, a, 1'b0, 1'b0);
    step(1'b1, b, 1'b0, 1'b0);
    step(1'b1, c, 1'b0, 1'b0);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  initial begin
    @(posedge clk); #1;
    check("reset_disp", disp, 16'h0000);
    check("reset_finish", {15'b0, finish}, 16'h0000);
    nrst = 1'b1;
    step(1'b1, 4'd1, 1'b0, 1'b0);
    step(1'b1, 4'd3, 1'b0, 1'b0);
    step(1'b1, 4'd0, 1'b0, 1'b0);
    step(1'b1, 4'd5, 1'b0, 1'b0);
    step(1'b1, 4'd7, 1'b0, 1'b0);
    check("entry", disp, 16'h3057);
    step(1'b1, 4'hB, 1'b0, 1'b0);
    check("bad_digit", disp, 16'h3057);
    load(4'd0, 4'd1, 4'd0, 4'd0);
    check("load_0100", disp, 16'h0100);
    repeat (4) step(1'b0, 4'd0, 1'b0, 1'b1);
    check("minute_borrow", disp, 16'h0059);
    repeat (236) step(1'b0, 4'd0, 1'b0, 1'b1);
    check("count_zero", disp, 16'h0000);
    check("finish_not_yet", {15'b0, finish}, 16'h0000);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    check("finish_rise", {15'b0, finish}, 16'h0001);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    check("finish_hold", {15'b0, finish}, 16'h0001);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    check("finish_drop", {15'b0, finish}, 16'h0000);
    load(4'd0, 4'd0, 4'd0, 4'd2);
    repeat (2) step(1'b0, 4'd0, 1'b0, 1'b1);
    repeat (10) step(1'b0, 4'd0, 1'b0, 1'b0);
    check("pause_hold", disp, 16'h0002);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    check("resume_1", disp, 16'h0002);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    check("resume_2", disp, 16'h0001);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    check("zero_start", {15'b0, finish}, 16'h0001);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    load(4'd0, 4'd0, 4'd3, 4'd0);
    repeat (5) step(1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b1, 1'b1);
    check("clear_stop", disp, 16'h0000);
    check("clear_stop_fin0", {15'b0, finish}, 16'h0000);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    check("clear_stop_fin1", {15'b0, finish}, 16'h0001);
    load(4'd0, 4'd0, 4'd1, 4'd5);
    repeat (8) step(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b1);
    check("ignored_entry", disp, 16'h0013);
    step(1'b1, 4'd5, 1'b1, 1'b0);
    check("clear_wins", disp, 16'h0000);
    load(4'd0, 4'd0, 4'd2, 4'd0);
    repeat (5) step(1'b0, 4'd0, 1'b0, 1'b1);
    nrst = 1'b0;
    #1;
    check("async_rst_disp", disp, 16'h0000);
    check("async_rst_finish", {15'b0, finish}, 16'h0000);
    heat = 1'b0;
    m = 0; s = 0; p = 0;
    #1;
    nrst = 1'b1;
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
